// File: rtl/sblk_act_feeder_if.sv
// Bus bundle between the activation feeder, its config/request source, the
// upstream activation stream and the act-buffer write port.
interface sblk_act_feeder_if #(
    parameter int unsigned WID_ACT     = 8,
    parameter int unsigned WID_INST_TN = 4,
    parameter int unsigned WID_INST_TP = 5
) ();
    logic                   cfg_en;
    logic [WID_INST_TN-1:0] cfg_n_tn;
    logic [WID_INST_TP-1:0] cfg_n_tp;
    logic                   act_in_req;
    logic                   src_vld;
    logic [2*WID_ACT-1:0]   src_data;
    logic                   src_rdy;
    logic                   act_in_vld;
    logic [2*WID_ACT-1:0]   act_in;
    logic                   busy;
    logic                   err_req_ovf;

    modport master (
        output cfg_en, cfg_n_tn, cfg_n_tp, act_in_req, src_vld, src_data,
        input  src_rdy, act_in_vld, act_in, busy, err_req_ovf
    );

    modport slave (
        input  cfg_en, cfg_n_tn, cfg_n_tp, act_in_req, src_vld, src_data,
        output src_rdy, act_in_vld, act_in, busy, err_req_ovf
    );
endinterface

// File: rtl/sblk_act_feeder.sv
// Activation batch feeder: prefetch FIFO plus a burst engine that emits exactly
// n_tn*n_tp*N_TILE words per request from the sub-block controller.
module sblk_act_feeder #(
    parameter int unsigned WID_ACT     = 8,
    parameter int unsigned N_TILE      = 4,
    parameter int unsigned WID_INST_TN = 4,
    parameter int unsigned WID_INST_TP = 5,
    parameter int unsigned FIFO_DEPTH  = 16
) (
    input  logic              clk_l,
    input  logic              rst_n,
    sblk_act_feeder_if.slave  bus
);
    localparam int unsigned WID_WORD = 2 * WID_ACT;
    localparam int unsigned WID_BLEN = WID_INST_TN + WID_INST_TP + $clog2(N_TILE);
    localparam int unsigned WID_PTR  = $clog2(FIFO_DEPTH);
    localparam int unsigned WID_CNT  = WID_PTR + 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    logic [WID_WORD-1:0] mem [FIFO_DEPTH];
    logic [WID_PTR-1:0]  wptr, wptr_nxt, rptr, rptr_nxt;
    logic [WID_CNT-1:0]  cnt, cnt_nxt;
    logic [WID_BLEN-1:0] blen, blen_nxt, remain, remain_nxt;
    state_t              state, state_nxt;
    logic                pending, pending_nxt;
    logic                err, err_nxt;
    logic                vld, vld_nxt;
    logic                busy, busy_nxt;
    logic [WID_WORD-1:0] word, word_nxt;
    logic                fifo_full, fifo_empty, push, pop, wr_en;

    // Ready depends only on the registered count, so push and pop may share an edge.
    assign fifo_full  = (cnt == WID_CNT'(FIFO_DEPTH));
    assign fifo_empty = (cnt == '0);
    assign push       = bus.src_vld & ~fifo_full;

    // Next-state, FIFO bookkeeping and output computation.
    always_comb begin
        state_nxt   = state;
        blen_nxt    = blen;
        remain_nxt  = remain;
        pending_nxt = pending;
        err_nxt     = err;
        wptr_nxt    = wptr;
        rptr_nxt    = rptr;
        cnt_nxt     = cnt;
        vld_nxt     = 1'b0;
        word_nxt    = word;
        busy_nxt    = busy;
        pop         = 1'b0;
        wr_en       = 1'b0;

        case (state)
            ST_IDLE: begin
                // A zero-length batch still consumes the request.
                if (bus.act_in_req || pending) begin
                    pending_nxt = 1'b0;
                    if (blen != '0) begin
                        remain_nxt = blen;
                        state_nxt  = ST_BURST;
                    end
                end
            end
            ST_BURST: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    remain_nxt = remain - WID_BLEN'(1);
                    if (remain == WID_BLEN'(1)) state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Requests that cannot launch this cycle are parked; a second one is a protocol error.
        if (bus.act_in_req && (state == ST_BURST || pending)) begin
            pending_nxt = 1'b1;
            if (pending) err_nxt = 1'b1;
        end

        if (pop) begin
            vld_nxt  = 1'b1;
            word_nxt = mem[rptr];
            rptr_nxt = rptr + WID_PTR'(1);
        end

        wr_en = push;
        if (push) wptr_nxt = wptr + WID_PTR'(1);

        if (push && !pop)      cnt_nxt = cnt + WID_CNT'(1);
        else if (!push && pop) cnt_nxt = cnt - WID_CNT'(1);

        busy_nxt = (state_nxt == ST_BURST) | pending_nxt;

        // Reconfiguration flushes everything and wins over all other events.
        if (bus.cfg_en) begin
            blen_nxt    = WID_BLEN'(bus.cfg_n_tn) * WID_BLEN'(bus.cfg_n_tp) * WID_BLEN'(N_TILE);
            wptr_nxt    = '0;
            rptr_nxt    = '0;
            cnt_nxt     = '0;
            pending_nxt = 1'b0;
            err_nxt     = 1'b0;
            state_nxt   = ST_IDLE;
            vld_nxt     = 1'b0;
            busy_nxt    = 1'b0;
            wr_en       = 1'b0;
        end
    end

    always_ff @(posedge clk_l) begin
        if (wr_en) mem[wptr] <= bus.src_data;
    end

    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            blen    <= '0;
            remain  <= '0;
            pending <= 1'b0;
            err     <= 1'b0;
            wptr    <= '0;
            rptr    <= '0;
            cnt     <= '0;
            vld     <= 1'b0;
            word    <= '0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            blen    <= blen_nxt;
            remain  <= remain_nxt;
            pending <= pending_nxt;
            err     <= err_nxt;
            wptr    <= wptr_nxt;
            rptr    <= rptr_nxt;
            cnt     <= cnt_nxt;
            vld     <= vld_nxt;
            word    <= word_nxt;
            busy    <= busy_nxt;
        end
    end

    assign bus.src_rdy     = ~fifo_full;
    assign bus.act_in_vld  = vld;
    assign bus.act_in      = word;
    assign bus.busy        = busy;
    assign bus.err_req_ovf = err;

endmodule

// File: doc/sblk_act_feeder.md
# sblk_act_feeder

Activation batch feeder that sits directly upstream of the sub-block controller's activation load port. It prefetches activation words from the upstream activation stream into a small FIFO. On each one-cycle `act_in_req` pulse from the sub-block controller, it issues exactly one batch of `n_tn*n_tp*N_TILE` words, using the `act_in_vld`/`act_in` interface that drives the act-buffer write counters.

## Interface
- `WID_ACT`, 8, activation element width; each word carries two elements (`2*WID_ACT` bits)
- `N_TILE`, 4, number of tiles per sub-block; must match the sub-block controller
- `WID_INST_TN`, 4, width of the `n_tn` field
- `WID_INST_TP`, 5, width of the `n_tp` field
- `WID_BLEN`, `WID_INST_TN+WID_INST_TP+$clog2(N_TILE)`, batch-length counter width
- `FIFO_DEPTH`, 16, prefetch FIFO depth; must be a power of 2 and ≥2

Ports:
- `clk_l` in 1 clock
- `rst_n` in 1 reset: asynchronous, active-low
- `cfg_en` in 1 one-cycle pulse; latches `cfg_n_tn`/`cfg_n_tp`, flushes the block
- `cfg_n_tn` in `WID_INST_TN` tile count along N
- `cfg_n_tp` in `WID_INST_TP` tile count along P
- `act_in_req` in 1 one-cycle batch request from the sub-block controller
- `src_vld` in 1 upstream word valid
- `src_data` in `2*WID_ACT` upstream word
- `src_rdy` out 1 upstream ready; equals `~fifo_full`
- `act_in_vld` out 1 registered word strobe to the sub-block controller
- `act_in` out `2*WID_ACT` registered word to the act buffer
- `busy` out 1 high while in BURST or while a request is pending
- `err_req_ovf` out 1 sticky flag; a request arrived while one was already pending

## Operation
- Config: on `cfg_en`, register `blen = cfg_n_tn*cfg_n_tp*N_TILE` (full `WID_BLEN` width, no truncation).
  - Also empty the FIFO (pointers to 0), clear `pending` and `err_req_ovf`, and force state to IDLE.
  - `cfg_en` takes priority over every other event in the same cycle.
- FIFO: push when `src_vld & src_rdy`.
  - `src_rdy` depends only on the registered count, so a push and a pop in the same cycle are legal; a full FIFO refuses the push even if a pop occurs.
  - Occupancy counter is `$clog2(FIFO_DEPTH)+1` bits.
- FSM, two states:
  - IDLE: if `act_in_req` or `pending`, and `blen != 0`: load `remain = blen`, clear `pending`, go to BURST. If `blen == 0`, drop the request (it consumes `pending`); stay in IDLE.
  - BURST: each cycle with FIFO non-empty, pop one word. Next cycle, drive `act_in_vld=1` and `act_in` = the popped word; decrement `remain`. When the word with `remain==1` is popped, return to IDLE in the same edge. Empty FIFO produces a bubble (`act_in_vld=0`), never a duplicate or dropped word.
- Requests: an `act_in_req` during BURST, or in IDLE while `pending` is already set, sets `pending`.
  - A request that arrives while `pending` is already 1 sets `err_req_ovf`; the extra request is discarded.
  - The sub-block controller issues at most one outstanding request, so `err_req_ovf` flags a protocol bug.
- Words per batch are exactly `blen`; words beyond `blen` stay in the FIFO for the next batch.

## Timing
- Reset values: `act_in_vld=0`, `act_in=0`, `src_rdy=1`, `busy=0`, `err_req_ovf=0`, state IDLE, `blen=0`, FIFO empty.
- Request latency with FIFO non-empty: `act_in_req` sampled at edge t, first pop at edge t+1, `act_in_vld` high in cycle t+1..t+2. That is 2 cycles from the request to the first valid word.
- With the FIFO pre-filled to ≥`blen` and no stalls, `act_in_vld` stays high for exactly `blen` consecutive cycles.
- Source-to-FIFO latency: a word pushed at edge t is poppable at edge t+1.
- Back-to-back batches:
  - A `pending` request is taken on the first IDLE cycle, giving one idle cycle between bursts.
  - `act_in_vld` gap is ≥1 cycle.
- `busy` is registered and rises the cycle after the accepting edge. It falls on the edge after the last pop if `pending=0`.
- `cfg_en` mid-BURST aborts the batch: `act_in_vld` is 0 from the next cycle, and the FIFO is emptied.

## Test plan
- **Basic batch:** `cfg_n_tn=2`, `cfg_n_tp=3`, `N_TILE=4` (blen=24); prefill 24 words 0..23; pulse `act_in_req`. Expect 24 consecutive `act_in_vld` cycles with data 0..23 in order, first one 2 cycles after the request, then `busy=0`.
- **Starved source:** same config, source gives one word every 3 cycles. Expect exactly 24 valid beats with bubbles, in order, no duplicates, and `src_rdy` never low.
- **Full FIFO:** `FIFO_DEPTH=16`, 20 words offered with no request. Expect `src_rdy=0` after 16 accepts. After a request with `blen=24`, all 20 words plus 4 more drain in order.
- **Pending and overflow:** second `act_in_req` during BURST gives a second batch of 24 after one idle cycle. A third request while `pending` sets `err_req_ovf=1`, sticky until `cfg_en`.
- **Abort and zero length:**
  - `cfg_en` at beat 10 of 24: `act_in_vld=0` next cycle, FIFO empty, `err_req_ovf` cleared.
  - `cfg_n_tp=0` then a request: no `act_in_vld`, `busy` stays 0.
- **Async reset:** `rst_n` low mid-BURST forces all outputs to reset values immediately; after release, the first request with a fresh config behaves as in the basic batch.
